// File: rtl/conv_out_buffer_if.sv
// Host-side bus of conv_out_buffer: result input, packing controls and FWFT readout.
interface conv_out_buffer_if #(
  parameter int IN_W  = 24,
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
);
  logic                         in_valid;
  logic [IN_W-1:0]              in_data;
  logic                         relu_en;
  logic [4:0]                   qshift;
  logic                         flush;
  logic                         clear;
  logic                         rd_en;
  logic [31:0]                  rd_data;
  logic                         empty;
  logic                         full;
  logic [$clog2(DEPTH):0]       count;
  logic [1:0]                   lane;
  logic                         overflow;
  logic [CNT_W-1:0]             res_cnt;

  modport master (
    output in_valid, in_data, relu_en, qshift, flush, clear, rd_en,
    input  rd_data, empty, full, count, lane, overflow, res_cnt
  );
  modport slave (
    input  in_valid, in_data, relu_en, qshift, flush, clear, rd_en,
    output rd_data, empty, full, count, lane, overflow, res_cnt
  );
endinterface

// File: rtl/conv_out_buffer.sv
// Requantizes signed conv results to bytes, packs four per word, queues words in a FWFT FIFO.
// Optional round-half-up before the shift: define CONV_OUT_ROUND_EN.
module conv_out_buffer #(
  parameter int IN_W  = 24,
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  conv_out_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [IN_W:0] S8_MAX = (IN_W+1)'(127);
  localparam logic signed [IN_W:0] S8_MIN = (IN_W+1)'(-128);
  localparam logic signed [IN_W:0] U8_MAX = (IN_W+1)'(255);

  logic clr;
  assign clr = rst | bus.clear;

  // Quantizer: one extra bit of headroom so rounding can never wrap.
  logic [4:0]              sh;
  logic signed [IN_W:0]    ext;
  logic signed [IN_W:0]    shifted;
  logic [7:0]              qbyte;
`ifdef CONV_OUT_ROUND_EN
  logic [IN_W:0]           rnd;
`endif

  always_comb begin
    sh  = (bus.qshift >= 5'(IN_W)) ? 5'(IN_W-1) : bus.qshift;
    ext = {bus.in_data[IN_W-1], bus.in_data};
`ifdef CONV_OUT_ROUND_EN
    rnd = '0;
    if (sh != 5'd0) begin
      rnd = (IN_W+1)'(1) << (sh - 5'd1);
      ext = ext + $signed(rnd);
    end
`endif
    shifted = ext >>> sh;
    if (bus.relu_en) begin
      if (bus.in_data[IN_W-1])   qbyte = 8'h00;
      else if (shifted > U8_MAX) qbyte = 8'hFF;
      else                       qbyte = shifted[7:0];
    end else begin
      if (shifted > S8_MAX)      qbyte = 8'h7F;
      else if (shifted < S8_MIN) qbyte = 8'h80;
      else                       qbyte = shifted[7:0];
    end
  end

  // Packer
  logic [1:0]  lane_q, lane_d;
  logic [23:0] pack_q, pack_d;
  logic [31:0] word;
  logic        push;

  always_comb begin
    word = {8'h00, pack_q};
    if (bus.in_valid) word[{lane_q, 3'b000} +: 8] = qbyte;
    // flush with a byte in hand always pushes exactly once, even at lane 0
    push = (bus.in_valid && lane_q == 2'd3) ||
           (bus.flush && (bus.in_valid || lane_q != 2'd0));
    lane_d = lane_q;
    pack_d = pack_q;
    if (push) begin
      lane_d = 2'd0;
      pack_d = '0;
    end else if (bus.in_valid) begin
      lane_d = lane_q + 2'd1;
      pack_d = word[23:0];
    end
  end

  // FIFO
  logic [31:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q;
  logic [CNT_W-1:0] res_cnt_q;
  logic             empty, full, pop, wr, drop;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CW'(DEPTH));
    pop   = bus.rd_en && !empty;
    wr    = push && (!full || pop);
    drop  = push && full && !pop;
    unique case ({wr, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      lane_q     <= '0;
      pack_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      res_cnt_q  <= '0;
    end else begin
      lane_q  <= lane_d;
      pack_q  <= pack_d;
      count_q <= count_d;
      if (wr)           wr_ptr_q   <= wr_ptr_q + AW'(1);
      if (pop)          rd_ptr_q   <= rd_ptr_q + AW'(1);
      if (drop)         overflow_q <= 1'b1;
      if (bus.in_valid) res_cnt_q  <= res_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && wr) mem_q[wr_ptr_q] <= word;
  end

  assign bus.rd_data  = empty ? 32'h0 : mem_q[rd_ptr_q];
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.lane     = lane_q;
  assign bus.overflow = overflow_q;
  assign bus.res_cnt  = res_cnt_q;
endmodule

// File: tb/tb_conv_out_buffer.sv
// Table-driven quantize/pack vectors plus hand sequences for flush, overflow, clear, wrap, reset.
module tb_conv_out_buffer;
  localparam int IN_W = 24, DEPTH = 4, CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_out_buffer_if #(.IN_W(IN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
  conv_out_buffer #(.IN_W(IN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] din;
    logic        relu;
    logic [4:0]  qs;
    logic [7:0]  exp_b;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.relu_en  = 1'b1;
    bus.qshift   = 5'd0;
    bus.in_data  = {16'h0, b};
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Pushes a whole word; optionally pops the scoreboard head on the completing cycle.
  task automatic push_word(input logic [31:0] w, input bit pop_last);
    bus.relu_en = 1'b1;
    bus.qshift  = 5'd0;
    for (int i = 0; i < 4; i++) begin
      bus.in_data  = {16'h0, w[i*8 +: 8]};
      bus.in_valid = 1'b1;
      if (i == 3 && pop_last) begin
        chk("rd_head_on_pop", bus.rd_data, exp_q.pop_front());
        bus.rd_en = 1'b1;
      end
      step();
      bus.in_valid = 1'b0;
      bus.rd_en    = 1'b0;
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      chk("empty_before_read", bus.empty, 0);
      chk("rd_data", bus.rd_data, exp_q.pop_front());
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
    end
    chk("empty_after_drain", bus.empty, 1);
  endtask

  initial begin
    logic [31:0] w;
    int          ln;

    vecs[0]  = '{24'h000005, 1'b1, 5'd0,  8'h05};
    vecs[1]  = '{24'hFFFFFE, 1'b1, 5'd0,  8'h00};
    vecs[2]  = '{24'h000120, 1'b1, 5'd0,  8'hFF};
    vecs[3]  = '{24'h00007F, 1'b1, 5'd0,  8'h7F};
    vecs[4]  = '{24'h000800, 1'b0, 5'd4,  8'h7F};
    vecs[5]  = '{24'hFFF000, 1'b0, 5'd4,  8'h80};
    vecs[6]  = '{24'h000010, 1'b0, 5'd4,  8'h01};
    vecs[7]  = '{24'hFFFFF0, 1'b0, 5'd4,  8'hFF};
`ifdef CONV_OUT_ROUND_EN
    vecs[8]  = '{24'h000018, 1'b0, 5'd4,  8'h02};
`else
    vecs[8]  = '{24'h000018, 1'b0, 5'd4,  8'h01};
`endif
    vecs[9]  = '{24'h800000, 1'b0, 5'd31, 8'hFF};
    vecs[10] = '{24'h000400, 1'b1, 5'd2,  8'hFF};
    vecs[11] = '{24'hFFFF00, 1'b0, 5'd1,  8'h80};
    vecs[12] = '{24'h800000, 1'b1, 5'd3,  8'h00};
    vecs[13] = '{24'h0000FF, 1'b1, 5'd0,  8'hFF};
    vecs[14] = '{24'h00FF00, 1'b1, 5'd8,  8'hFF};
    vecs[15] = '{24'h00007F, 1'b0, 5'd0,  8'h7F};

    bus.in_valid = 1'b0; bus.in_data = '0; bus.relu_en = 1'b0; bus.qshift = '0;
    bus.flush = 1'b0; bus.clear = 1'b0; bus.rd_en = 1'b0;
    step(); step();
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_lane", bus.lane, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_res_cnt", bus.res_cnt, 0);
    rst = 1'b0;

    // Quantize/pack vectors: 16 results -> 4 words, exactly filling the FIFO.
    w = '0; ln = 0;
    for (int i = 0; i < 16; i++) begin
      bus.in_data  = vecs[i].din;
      bus.relu_en  = vecs[i].relu;
      bus.qshift   = vecs[i].qs;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      w[ln*8 +: 8] = vecs[i].exp_b;
      if (ln == 3) begin
        exp_q.push_back(w);
        w = '0; ln = 0;
      end else ln++;
      chk("vec_lane", bus.lane, ln);
      chk("vec_res_cnt", bus.res_cnt, i + 1);
      chk("vec_count", bus.count, exp_q.size());
      if (i == 3) begin
        chk("word1_empty", bus.empty, 0);
        chk("word1_rd_data", bus.rd_data, 32'h7FFF0005);
      end
    end
    chk("table_full", bus.full, 1);
    chk("table_overflow", bus.overflow, 0);
    drain();

    // Flush: partial word, idle flush, flush completing a word, flush at lane 0.
    push_byte(8'h11); push_byte(8'h22);
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    exp_q.push_back(32'h00002211);
    chk("flush_lane", bus.lane, 0);
    chk("flush_count", bus.count, 1);
    chk("flush_rd_data", bus.rd_data, 32'h00002211);
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    chk("flush_noop_count", bus.count, 1);
    push_byte(8'h33); push_byte(8'h44); push_byte(8'h55);
    bus.in_data = 24'h66; bus.in_valid = 1'b1; bus.flush = 1'b1;
    step();
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    exp_q.push_back(32'h66554433);
    chk("flush_full_word_count", bus.count, 2);
    bus.in_data = 24'h77; bus.in_valid = 1'b1; bus.flush = 1'b1;
    step();
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    exp_q.push_back(32'h00000077);
    chk("flush_lane0_count", bus.count, 3);
    chk("flush_lane0_lane", bus.lane, 0);
    drain();

    // Overflow: 5 words into a 4-deep FIFO, then push+pop while full.
    for (int k = 0; k < 5; k++) begin
      push_word(32'hA0B0C000 + k, 1'b0);
      if (k < 4) exp_q.push_back(32'hA0B0C000 + k);
      if (k == 3) begin
        chk("ovf_full", bus.full, 1);
        chk("ovf_count4", bus.count, 4);
        chk("ovf_not_yet", bus.overflow, 0);
      end
    end
    chk("ovf_sticky", bus.overflow, 1);
    chk("ovf_count_hold", bus.count, 4);
    push_word(32'hA0B0C005, 1'b1);
    exp_q.push_back(32'hA0B0C005);
    chk("pushpop_count", bus.count, 4);
    chk("pushpop_overflow", bus.overflow, 1);
    chk("pushpop_head", bus.rd_data, 32'hA0B0C001);
    drain();
    chk("ovf_still_sticky", bus.overflow, 1);

    // Soft clear wins over a coincident in_valid.
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    bus.in_data = 24'h04; bus.in_valid = 1'b1; bus.clear = 1'b1;
    step();
    bus.in_valid = 1'b0; bus.clear = 1'b0;
    chk("clr_lane", bus.lane, 0);
    chk("clr_count", bus.count, 0);
    chk("clr_empty", bus.empty, 1);
    chk("clr_overflow", bus.overflow, 0);
    chk("clr_res_cnt", bus.res_cnt, 0);
    bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
    chk("rd_empty_count", bus.count, 0);
    chk("rd_empty_data", bus.rd_data, 0);
    chk("rd_empty_empty", bus.empty, 1);

    // Pointer wrap: 10 words streamed through with one word kept in flight.
    for (int k = 0; k < 10; k++) begin
      push_word(32'h5A000000 + (k << 8) + k, k >= 1);
      exp_q.push_back(32'h5A000000 + (k << 8) + k);
      chk("wrap_count", bus.count, 1);
    end
    drain();

    // Reset mid-stream.
    push_word(32'hCAFEF00D, 1'b0);
    exp_q.push_back(32'hCAFEF00D);
    push_byte(8'h99);
    rst = 1'b1; step(); rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_empty", bus.empty, 1);
    chk("mid_rst_rd_data", bus.rd_data, 0);
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_lane", bus.lane, 0);
    chk("mid_rst_res_cnt", bus.res_cnt, 0);
    chk("mid_rst_full", bus.full, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
